instruction_fetch_unit: RTL

//  IF-stage producer feeding the IF/ID pipeline register: owns the PC, fetches from imem over a req/rsp handshake.

---
 rtl/instruction_fetch_unit_if.sv | 30 +++
 rtl/instruction_fetch_unit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit and imem.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready handshake on the request; responses are not backpressured.
interface instruction_fetch_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req_valid_o;
  logic                  imem_req_ready_i;
  logic [DATA_WIDTH-1:0] imem_req_addr_o;
  logic                  imem_rsp_valid_i;
  logic [DATA_WIDTH-1:0] imem_rsp_data_i;

  // Fetch unit side: issues requests and consumes responses.
  modport master (
    output imem_req_valid_o,
    output imem_req_addr_o,
    input  imem_req_ready_i,
    input  imem_rsp_valid_i,
    input  imem_rsp_data_i
  );

  // Memory side: accepts requests and returns responses.
  modport slave (
    input  imem_req_valid_o,
    input  imem_req_addr_o,
    output imem_req_ready_i,
    output imem_rsp_valid_i,
    output imem_rsp_data_i
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, fetches from imem with one request in flight, presents {instr, pc, pc+4} to IF/ID.
// Latency: request issued in REQ, response captured one edge after it arrives; best case 3 cycles per instruction.
// Backpressure: holds request while imem_req_ready_i=0; holds presented instruction while IF_ID_write_en_i=0.
module instruction_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       IF_ID_write_en_i,
  input  logic                       redirect_i,
  input  logic [DATA_WIDTH-1:0]      redirect_pc_i,
  instruction_fetch_unit_if.master   imem,
  output logic                       IF_valid_o,
  output logic [DATA_WIDTH-1:0]      IF_instruction_o,
  output logic [DATA_WIDTH-1:0]      IF_pc_o,
  output logic [DATA_WIDTH-1:0]      IF_pc_plus4_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] out_pc_q, out_pc_d;
  logic [DATA_WIDTH-1:0] out_pc4_q, out_pc4_d;

  logic [DATA_WIDTH-1:0] redir_pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  req_accept;

  // Low address bits of a redirect target are dropped so pc_q stays word aligned.
  assign redir_pc = redirect_pc_i & ~DATA_WIDTH'(3);
  assign pc_plus4 = pc_q + DATA_WIDTH'(4);

  // Request is decoded from state; gated by rst_n so nothing is offered while reset is held.
  assign imem.imem_req_valid_o = (state_q == S_REQ) && rst_n;
  assign imem.imem_req_addr_o  = pc_q;
  assign req_accept            = imem.imem_req_valid_o && imem.imem_req_ready_i;

  assign IF_valid_o       = valid_q;
  assign IF_instruction_o = instr_q;
  assign IF_pc_o          = out_pc_q;
  assign IF_pc_plus4_o    = out_pc4_q;

  // Next-state logic: redirect outranks every other event in every state.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    out_pc_d  = out_pc_q;
    out_pc4_d = out_pc4_q;
    case (state_q)
      S_REQ: begin
        if (redirect_i) begin
          pc_d    = redir_pc;
          // A request accepted in the redirect cycle is for the old path; its response must be dropped.
          state_d = req_accept ? S_DROP : S_REQ;
        end else if (req_accept) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_i) begin
          pc_d    = redir_pc;
          // If the stale response lands now it is simply ignored; otherwise wait it out in DROP.
          state_d = imem.imem_rsp_valid_i ? S_REQ : S_DROP;
        end else if (imem.imem_rsp_valid_i) begin
          instr_d   = imem.imem_rsp_data_i;
          out_pc_d  = pc_q;
          out_pc4_d = pc_plus4;
          valid_d   = 1'b1;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          pc_d    = redir_pc;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = S_REQ;
        end else if (IF_ID_write_en_i) begin
          pc_d    = pc_plus4;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_i) begin
          pc_d = redir_pc;
        end
        // The outstanding stale response retires the drop even if a redirect arrives with it,
        // otherwise the unit would wait for a response that never comes.
        if (imem.imem_rsp_valid_i) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // State and output registers; asynchronous reset returns to a fetch of RESET_PC with a NOP bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      instr_q   <= NOP_INSTR;
      out_pc_q  <= '0;
      out_pc4_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      out_pc_q  <= out_pc_d;
      out_pc4_q <= out_pc4_d;
    end
  end

endmodule
